// File: rtl/sn74xx157_arb.sv
// Two-requester arbiter driving one SN74XX157 quad 2:1 mux (sel/str).
// Optional lock input enabled by SN74XX157_ARB_LOCK_EN.
module sn74xx157_arb #(
  parameter int MAX_HOLD = 4,
  parameter int GAP      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
`ifdef SN74XX157_ARB_LOCK_EN
  input  logic lock,
`endif
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic str,
  output logic last
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B,
    TURN
  } state_t;

  localparam logic [3:0] MH = 4'(MAX_HOLD);
  localparam logic [2:0] GP = 3'(GAP);

  state_t     state, state_n;
  logic [3:0] hold_cnt, hold_n;
  logic [2:0] gap_cnt, gap_n;
  logic       gnt_a_n, gnt_b_n, sel_n, str_n, last_n;
  logic       lk, win_a, win_b, hold_full;

`ifdef SN74XX157_ARB_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif

  // A tie goes to whichever side was not served last
  assign win_a     = req_a & (~req_b | last);
  assign win_b     = req_b & (~req_a | ~last);
  assign hold_full = (hold_cnt == MH);

  // State and registered mux controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      sel      <= 1'b0;
      str      <= 1'b1;
      last     <= 1'b1;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      gnt_a    <= gnt_a_n;
      gnt_b    <= gnt_b_n;
      sel      <= sel_n;
      str      <= str_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
    end
  end

  // Next-state: arbitrate, hold-limit, and strobe-high turnaround
  always_comb begin
    state_n = state;
    gnt_a_n = gnt_a;
    gnt_b_n = gnt_b;
    sel_n   = sel;
    str_n   = str;
    last_n  = last;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    unique case (state)
      IDLE, TURN: begin
        if (state == TURN && gap_cnt < GP) begin
          gap_n = gap_cnt + 3'd1;
        end else begin
          unique case (1'b1)
            win_a: begin
              state_n = OWN_A;
              gnt_a_n = 1'b1;
              sel_n   = 1'b0;
              str_n   = 1'b0;
              hold_n  = 4'd1;
              last_n  = 1'b0;
            end
            win_b: begin
              state_n = OWN_B;
              gnt_b_n = 1'b1;
              sel_n   = 1'b1;
              str_n   = 1'b0;
              hold_n  = 4'd1;
              last_n  = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      OWN_A, OWN_B: begin
        if ((state == OWN_A) ? !req_a : !req_b) begin
          state_n = TURN;
        end else if (req_a && req_b && hold_full && !lk) begin
          state_n = TURN;
        end else if (!hold_full) begin
          hold_n = hold_cnt + 4'd1;
        end
        if (state_n == TURN) begin
          gnt_a_n = 1'b0;
          gnt_b_n = 1'b0;
          str_n   = 1'b1;
          gap_n   = 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sn74xx157_arb.sv
// Directed bench for sn74xx157_arb: default instance plus a GAP=3 instance.
// Expected output vectors are {gnt_a,gnt_b,sel,str,last}.
module tb_sn74xx157_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic ga = 1'b0, gb = 1'b0;
  logic gnt_a, gnt_b, sel, str, last;
  logic g_gnt_a, g_gnt_b, g_sel, g_str, g_last;
`ifdef SN74XX157_ARB_LOCK_EN
  logic lock = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] AV = 4'b1010;
  localparam logic [3:0] BV = 4'b1111;

  always #5 clk = ~clk;

  sn74xx157_arb u_dut (
    .clk  (clk),
    .rst  (rst),
    .req_a(req_a),
    .req_b(req_b),
`ifdef SN74XX157_ARB_LOCK_EN
    .lock (lock),
`endif
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .sel  (sel),
    .str  (str),
    .last (last)
  );

  sn74xx157_arb #(.MAX_HOLD(4), .GAP(3)) u_gap (
    .clk  (clk),
    .rst  (rst),
    .req_a(ga),
    .req_b(gb),
`ifdef SN74XX157_ARB_LOCK_EN
    .lock (1'b0),
`endif
    .gnt_a(g_gnt_a),
    .gnt_b(g_gnt_b),
    .sel  (g_sel),
    .str  (g_str),
    .last (g_last)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {3'b0, gnt_a, gnt_b, sel, str, last};
  endfunction

  function automatic logic [7:0] g_outs();
    return {3'b0, g_gnt_a, g_gnt_b, g_sel, g_str, g_last};
  endfunction

  function automatic logic [7:0] mux_out();
    return {4'b0, (str ? 4'b0000 : (sel ? BV : AV))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    int p;
    // reset
    step();
    chk("reset", outs(), 8'b00011);
    chk("reset_gap", g_outs(), 8'b00011);
    @(negedge clk);
    rst = 1'b0;

    // single requester A for 6 cycles
    req_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("single_a", outs(), 8'b10000);
      chk("single_mux", mux_out(), {4'b0, AV});
    end
    req_a = 1'b0;
    step();
    chk("single_turn", outs(), 8'b00010);
    chk("turn_mux", mux_out(), 8'h00);
    step();
    chk("single_idle", outs(), 8'b00010);

    // async reset mid-grant
    req_a = 1'b1;
    step();
    chk("pre_rst", outs(), 8'b10000);
    #2 rst = 1'b1;
    #1 chk("async_rst", outs(), 8'b00011);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // contention from reset: A4, gap, B4, gap, ...
    req_a = 1'b1;
    req_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      p = k % 10;
      if (p < 4) e = 8'b10000;
      else if (p == 4) e = 8'b00010;
      else if (p < 9) e = 8'b01101;
      else e = 8'b00111;
      chk($sformatf("cont_%0d", k), outs(), e);
      chk("cont_excl", {7'b0, gnt_a & gnt_b}, 8'h00);
      if (p < 4) chk("cont_mux_a", mux_out(), {4'b0, AV});
      else if (p > 4 && p < 9) chk("cont_mux_b", mux_out(), {4'b0, BV});
      else chk("cont_mux_gap", mux_out(), 8'h00);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("cont_idle", outs(), 8'b00111);

    // simultaneous release of A and request of B
    req_a = 1'b1;
    step();
    chk("rel_a1", outs(), 8'b10000);
    step();
    chk("rel_a2", outs(), 8'b10000);
    req_a = 1'b0;
    req_b = 1'b1;
    step();
    chk("rel_turn", outs(), 8'b00010);
    step();
    chk("rel_b", outs(), 8'b01101);

    // B alone holds past MAX_HOLD, then A preempts at saturation
    for (int i = 0; i < 7; i++) begin
      step();
      chk("b_unlimited", outs(), 8'b01101);
    end
    req_a = 1'b1;
    step();
    chk("preempt_turn", outs(), 8'b00111);
    step();
    chk("preempt_a", outs(), 8'b10000);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("end_turn", outs(), 8'b00010);
    step();
    chk("end_idle", outs(), 8'b00010);

    // GAP=3 instance: A pulse, then B after exactly 3 strobe-high cycles
    ga = 1'b1;
    step();
    chk("gap_a1", g_outs(), 8'b10000);
    step();
    chk("gap_a2", g_outs(), 8'b10000);
    ga = 1'b0;
    gb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("gap_str_%0d", i), g_outs(), 8'b00010);
    end
    step();
    chk("gap_b", g_outs(), 8'b01101);
    gb = 1'b0;
    step();
    chk("gap_b_turn", g_outs(), 8'b00111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
